// File: rtl/mspc_v_alu_sched_pkg.sv
// Shared constants and types for the two-port ALU scheduler slice:
// FSM state encoding, requester port indices and default datapath widths.
package mspc_v_pkg;

  localparam int W    = 64;
  localparam int SELW = 4;

  localparam logic P_EXE = 1'b0;
  localparam logic P_AGU = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // One-hot request/response vector for a single port index.
  function automatic logic [1:0] port_onehot(input logic idx);
    logic [1:0] oh;
    oh = idx ? 2'b10 : 2'b01;
    return oh;
  endfunction

endpackage

// File: rtl/mspc_v_alu_sched_if.sv
// Request/response bundle between the two requesters and the ALU scheduler.
// Port p occupies slice [p*W +: W] of the operand buses and [p*SELW +: SELW]
// of the select bus; the response data is shared by both ports.
interface mspc_v_alu_sched_if #(
  parameter int W    = mspc_v_pkg::W,
  parameter int SELW = mspc_v_pkg::SELW
);

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [2*W-1:0]    req_inpa;
  logic [2*W-1:0]    req_inpb;
  logic [2*SELW-1:0] req_sel;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [W-1:0]      rsp_numoutp;
  logic              rsp_booloutp;

  modport master (
    output req_valid, req_inpa, req_inpb, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_numoutp, rsp_booloutp
  );

  modport slave (
    input  req_valid, req_inpa, req_inpb, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_numoutp, rsp_booloutp
  );

endinterface

// File: rtl/mspc_v_alu_sched_rr_arb2.sv
// Two-way round-robin arbiter. A lone requester always wins; when both
// request, the port named by prio wins. Grants are suppressed when en is low.
module mspc_v_rr_arb2
  import mspc_v_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       winner
);

  // Pick the winner index and its one-hot grant.
  always_comb begin
    gnt    = 2'b00;
    winner = P_EXE;
    if (en) begin
      case (req)
        2'b01:   winner = P_EXE;
        2'b10:   winner = P_AGU;
        2'b11:   winner = prio;
        default: winner = P_EXE;
      endcase
      if (req != 2'b00) begin
        gnt = port_onehot(winner);
      end else begin
        gnt = 2'b00;
      end
    end else begin
      gnt    = 2'b00;
      winner = P_EXE;
    end
  end

endmodule

// File: rtl/mspc_v_alu_sched.sv
// Two-port scheduler for the shared combinational 64-bit ALU.
// The winner's operands are registered onto the ALU inputs (EXEC), the ALU
// result is captured one cycle later and held for the winner's response
// handshake (RESP). Optional perf counters: MSPC_ALU_SCHED_PERF_EN.
module mspc_v_alu_sched #(
  parameter int W    = mspc_v_pkg::W,
  parameter int SELW = mspc_v_pkg::SELW
`ifdef MSPC_ALU_SCHED_PERF_EN
  ,
  parameter int CNTW = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  mspc_v_alu_sched_if.slave bus,
  output logic [W-1:0]     alu_inpa,
  output logic [W-1:0]     alu_inpb,
  output logic [SELW-1:0]  alu_sel,
  input  logic [W-1:0]     alu_numoutp,
  input  logic             alu_booloutp,
  output logic             busy
`ifdef MSPC_ALU_SCHED_PERF_EN
  ,
  output logic [CNTW-1:0]  perf_gnt0,
  output logic [CNTW-1:0]  perf_gnt1,
  output logic [CNTW-1:0]  perf_stall
`endif
);

  import mspc_v_pkg::*;

  state_e          state_q, state_d;
  logic            prio_q, prio_d;
  logic            gnt_q, gnt_d;
  logic [W-1:0]    alu_inpa_q, alu_inpa_d;
  logic [W-1:0]    alu_inpb_q, alu_inpb_d;
  logic [SELW-1:0] alu_sel_q, alu_sel_d;
  logic [W-1:0]    rsp_num_q, rsp_num_d;
  logic            rsp_bool_q, rsp_bool_d;
  logic [1:0]      rsp_valid_q, rsp_valid_d;
  logic            busy_q, busy_d;

  logic [1:0]      arb_gnt_s;
  logic            arb_win_s;
  logic            arb_en_s;
  logic            accept_s;
  logic            rsp_fire_s;
  logic [W-1:0]    win_inpa_s;
  logic [W-1:0]    win_inpb_s;
  logic [SELW-1:0] win_sel_s;

  // Requests are only offered while idle and out of reset, so req_ready
  // reads zero during reset even with requests pending.
  assign arb_en_s = (state_q == IDLE) && rst_n;

  mspc_v_rr_arb2 u_arb (
    .req    (bus.req_valid),
    .prio   (prio_q),
    .en     (arb_en_s),
    .gnt    (arb_gnt_s),
    .winner (arb_win_s)
  );

  assign accept_s      = |arb_gnt_s;
  assign bus.req_ready = arb_gnt_s;

  // rsp_valid_q only ever has the granted bit set, so the other port's
  // rsp_ready cannot complete the handshake.
  assign rsp_fire_s = |(rsp_valid_q & bus.rsp_ready);

  // Steer the winning port's operands toward the ALU input registers.
  always_comb begin
    if (arb_win_s == P_AGU) begin
      win_inpa_s = bus.req_inpa[2*W-1:W];
      win_inpb_s = bus.req_inpb[2*W-1:W];
      win_sel_s  = bus.req_sel[2*SELW-1:SELW];
    end else begin
      win_inpa_s = bus.req_inpa[W-1:0];
      win_inpb_s = bus.req_inpb[W-1:0];
      win_sel_s  = bus.req_sel[SELW-1:0];
    end
  end

  // Next-state and datapath updates for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    gnt_d       = gnt_q;
    alu_inpa_d  = alu_inpa_q;
    alu_inpb_d  = alu_inpb_q;
    alu_sel_d   = alu_sel_q;
    rsp_num_d   = rsp_num_q;
    rsp_bool_d  = rsp_bool_q;
    rsp_valid_d = rsp_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          alu_inpa_d  = win_inpa_s;
          alu_inpb_d  = win_inpb_s;
          alu_sel_d   = win_sel_s;
          gnt_d       = arb_win_s;
          prio_d      = ~arb_win_s;
          rsp_valid_d = 2'b00;
          busy_d      = 1'b1;
          state_d     = EXEC;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      EXEC: begin
        rsp_num_d   = alu_numoutp;
        rsp_bool_d  = alu_booloutp;
        rsp_valid_d = port_onehot(gnt_q);
        busy_d      = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_fire_s) begin
          rsp_valid_d = 2'b00;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        rsp_valid_d = 2'b00;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // Scheduler state and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      gnt_q       <= 1'b0;
      alu_inpa_q  <= {W{1'b0}};
      alu_inpb_q  <= {W{1'b0}};
      alu_sel_q   <= {SELW{1'b0}};
      rsp_num_q   <= {W{1'b0}};
      rsp_bool_q  <= 1'b0;
      rsp_valid_q <= 2'b00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      gnt_q       <= gnt_d;
      alu_inpa_q  <= alu_inpa_d;
      alu_inpb_q  <= alu_inpb_d;
      alu_sel_q   <= alu_sel_d;
      rsp_num_q   <= rsp_num_d;
      rsp_bool_q  <= rsp_bool_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign alu_inpa         = alu_inpa_q;
  assign alu_inpb         = alu_inpb_q;
  assign alu_sel          = alu_sel_q;
  assign bus.rsp_numoutp  = rsp_num_q;
  assign bus.rsp_booloutp = rsp_bool_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign busy             = busy_q;

`ifdef MSPC_ALU_SCHED_PERF_EN
  logic [CNTW-1:0] perf_gnt0_q, perf_gnt0_d;
  logic [CNTW-1:0] perf_gnt1_q, perf_gnt1_d;
  logic [CNTW-1:0] perf_stall_q, perf_stall_d;
  logic            stall_s;

  // Saturating increment: the counter sticks at all-ones.
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    logic [CNTW-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + {{(CNTW-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  // A cycle stalls when any requesting port is not being accepted.
  assign stall_s = |(bus.req_valid & ~arb_gnt_s);

  // Next values of the grant and stall counters.
  always_comb begin
    perf_gnt0_d  = perf_gnt0_q;
    perf_gnt1_d  = perf_gnt1_q;
    perf_stall_d = perf_stall_q;
    if (accept_s && (arb_win_s == P_EXE)) begin
      perf_gnt0_d = sat_inc(perf_gnt0_q);
    end else begin
      perf_gnt0_d = perf_gnt0_q;
    end
    if (accept_s && (arb_win_s == P_AGU)) begin
      perf_gnt1_d = sat_inc(perf_gnt1_q);
    end else begin
      perf_gnt1_d = perf_gnt1_q;
    end
    if (stall_s) begin
      perf_stall_d = sat_inc(perf_stall_q);
    end else begin
      perf_stall_d = perf_stall_q;
    end
  end

  // Perf counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_gnt0_q  <= {CNTW{1'b0}};
      perf_gnt1_q  <= {CNTW{1'b0}};
      perf_stall_q <= {CNTW{1'b0}};
    end else begin
      perf_gnt0_q  <= perf_gnt0_d;
      perf_gnt1_q  <= perf_gnt1_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_gnt0  = perf_gnt0_q;
  assign perf_gnt1  = perf_gnt1_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_mspc_v_alu_sched.sv
// Directed + randomized bench for mspc_v_alu_sched with a transaction-level
// reference model (arbitration rule, expected result, grant/stall tallies).
module tb_mspc_v_alu_sched;

  localparam int W    = 64;
  localparam int SELW = 4;
  localparam int CW   = W + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mspc_v_alu_sched_if #(.W(W), .SELW(SELW)) bus ();

  logic [W-1:0]    alu_inpa, alu_inpb, alu_numoutp;
  logic [SELW-1:0] alu_sel;
  logic            alu_booloutp;
  logic            busy;
`ifdef MSPC_ALU_SCHED_PERF_EN
  logic [15:0] perf_gnt0, perf_gnt1, perf_stall;
`endif

  mspc_v_alu_sched #(.W(W), .SELW(SELW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .alu_inpa     (alu_inpa),
    .alu_inpb     (alu_inpb),
    .alu_sel      (alu_sel),
    .alu_numoutp  (alu_numoutp),
    .alu_booloutp (alu_booloutp),
    .busy         (busy)
`ifdef MSPC_ALU_SCHED_PERF_EN
    ,
    .perf_gnt0    (perf_gnt0),
    .perf_gnt1    (perf_gnt1),
    .perf_stall   (perf_stall)
`endif
  );

  int vecs = 0;
  int errs = 0;

  // Reference model state.
  logic            prio_m   = 1'b0;
  logic            exp_idle = 1'b1;
  int              g0_m = 0, g1_m = 0, stall_exp = 0;
  logic [W-1:0]    pa [2];
  logic [W-1:0]    pb [2];
  logic [SELW-1:0] ps [2];

  // External ALU model: {booloutp, numoutp}.
  function automatic logic [W:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [SELW-1:0] s);
    logic [W-1:0] n;
    logic         bo;
    case (s)
      4'd0:    n = a + b;
      4'd1:    n = a - b;
      4'd2:    n = a & b;
      4'd3:    n = a | b;
      4'd4:    n = a ^ b;
      4'd5:    n = a << b[5:0];
      default: n = ~(a + b) ^ {60'd0, s};
    endcase
    bo = (s == 4'd6) ? (a < b) : (n == 64'd0);
    return {bo, n};
  endfunction

  always_comb begin
    {alu_booloutp, alu_numoutp} = alu_fn(alu_inpa, alu_inpb, alu_sel);
  end

  // Who should be offered req_ready while idle: lone requester, or prio on contention.
  function automatic logic [1:0] exp_ready(input logic [1:0] v, input logic pr);
    logic [1:0] r;
    if (v == 2'b11) r = pr ? 2'b10 : 2'b01;
    else            r = v;
    return r;
  endfunction

  // Stall tally: a cycle stalls if some valid port is not expected to be accepted.
  always @(negedge clk) begin
    logic [1:0] r;
    r = exp_idle ? exp_ready(bus.req_valid, prio_m) : 2'b00;
    if ((rst_n === 1'b1) && ((bus.req_valid & ~r) != 2'b00)) stall_exp++;
  end

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_port(input int p);
    bus.req_inpa[p*W +: W]       = pa[p];
    bus.req_inpb[p*W +: W]       = pb[p];
    bus.req_sel[p*SELW +: SELW]  = ps[p];
  endtask

  task automatic new_ops(input int p);
    pa[p] = {$urandom, $urandom};
    pb[p] = {$urandom, $urandom};
    ps[p] = SELW'($urandom_range(0, 15));
    drive_port(p);
  endtask

  // One full transaction starting in an idle cycle; bp = stalled RESP cycles.
  task automatic run_op(input logic [1:0] v, input int bp, output logic [1:0] rdy_obs);
    logic         w;
    logic [1:0]   oh;
    logic [W:0]   exp_r;
    logic [W-1:0] ea, eb;
    logic [SELW-1:0] es;
    for (int p = 0; p < 2; p++) begin
      if (v[p] && !bus.req_valid[p]) new_ops(p);
    end
    bus.req_valid = v;
    #1;
    rdy_obs = bus.req_ready;
    chk("req_ready_idle", CW'(bus.req_ready), CW'(exp_ready(v, prio_m)));
    w     = (v == 2'b11) ? prio_m : v[1];
    oh    = w ? 2'b10 : 2'b01;
    ea    = pa[w];
    eb    = pb[w];
    es    = ps[w];
    exp_r = alu_fn(ea, eb, es);
    @(posedge clk); #1;
    prio_m   = ~w;
    exp_idle = 1'b0;
    if (w) g1_m++; else g0_m++;
    chk("busy_exec",      CW'(busy),          CW'(1'b1));
    chk("rsp_valid_exec", CW'(bus.rsp_valid), CW'(2'b00));
    chk("req_ready_exec", CW'(bus.req_ready), CW'(2'b00));
    chk("alu_inpa",       CW'(alu_inpa),      CW'(ea));
    chk("alu_inpb",       CW'(alu_inpb),      CW'(eb));
    chk("alu_sel",        CW'(alu_sel),       CW'(es));
    new_ops(int'(w));
    bus.rsp_ready = (bp == 0) ? oh : ~oh;
    @(posedge clk); #1;
    chk("rsp_valid_resp", CW'(bus.rsp_valid),    CW'(oh));
    chk("rsp_numoutp",    CW'(bus.rsp_numoutp),  CW'(exp_r[W-1:0]));
    chk("rsp_booloutp",   CW'(bus.rsp_booloutp), CW'(exp_r[W]));
    chk("busy_resp",      CW'(busy),             CW'(1'b1));
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      chk("bp_rsp_valid", CW'(bus.rsp_valid),   CW'(oh));
      chk("bp_numoutp",   CW'(bus.rsp_numoutp), CW'(exp_r[W-1:0]));
      chk("bp_req_ready", CW'(bus.req_ready),   CW'(2'b00));
      chk("bp_alu_inpa",  CW'(alu_inpa),        CW'(ea));
      if (i == bp - 1) bus.rsp_ready = oh;
    end
    @(posedge clk); #1;
    exp_idle = 1'b1;
    chk("rsp_valid_done", CW'(bus.rsp_valid), CW'(2'b00));
    chk("busy_done",      CW'(busy),          CW'(1'b0));
  endtask

  // Watchdog: the sequence below is fixed-length, so this only fires on a hang.
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rdy;
    logic [1:0] want;
    logic [1:0] rv;

    // Reset with both ports requesting.
    rst_n          = 1'b0;
    bus.rsp_ready  = 2'b00;
    bus.req_valid  = 2'b00;
    bus.req_inpa   = '0;
    bus.req_inpb   = '0;
    bus.req_sel    = '0;
    new_ops(0);
    new_ops(1);
    bus.req_valid  = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", CW'(bus.req_ready), CW'(2'b00));
    chk("rst_rsp_valid", CW'(bus.rsp_valid), CW'(2'b00));
    chk("rst_busy",      CW'(busy),          CW'(1'b0));
    chk("rst_alu_inpa",  CW'(alu_inpa),      CW'(64'd0));
    chk("rst_alu_inpb",  CW'(alu_inpb),      CW'(64'd0));
    chk("rst_alu_sel",   CW'(alu_sel),       CW'(4'd0));
    chk("rst_numoutp",   CW'(bus.rsp_numoutp), CW'(64'd0));

    // Release reset with no requests: must stay idle.
    bus.req_valid = 2'b00;
    rst_n         = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", CW'(busy), CW'(1'b0));

    // Single op on port 0: 5 + 3 = 8.
    pa[0] = 64'd5; pb[0] = 64'd3; ps[0] = 4'd0;
    drive_port(0);
    bus.req_valid = 2'b01;
    run_op(2'b01, 0, rdy);
    bus.req_valid = 2'b00;

    // Backpressure on lone port 1 for 5 cycles.
    run_op(2'b10, 5, rdy);
    bus.req_valid = 2'b00;

    // Continuous contention: grants alternate 0,1,0,1.
    for (int i = 0; i < 4; i++) begin
      want = ((i % 2) == 0) ? 2'b01 : 2'b10;
      run_op(2'b11, 0, rdy);
      chk("contention_order", CW'(rdy), CW'(want));
    end

    // Randomized mix of requesters and response backpressure.
    for (int i = 0; i < 16; i++) begin
      rv = 2'($urandom_range(1, 3));
      run_op(rv, int'($urandom_range(0, 3)), rdy);
    end
    bus.req_valid = 2'b00;
    @(posedge clk); #1;

`ifdef MSPC_ALU_SCHED_PERF_EN
    chk("perf_gnt0",  CW'(perf_gnt0),  CW'(g0_m));
    chk("perf_gnt1",  CW'(perf_gnt1),  CW'(g1_m));
    chk("perf_stall", CW'(perf_stall), CW'(stall_exp));
`endif

    // Reset in EXEC on a port-0 op: response discarded, prio back to 0.
    new_ops(0);
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b11;
    @(posedge clk); #1;
    exp_idle = 1'b0;
    chk("midop_busy", CW'(busy), CW'(1'b1));
    rst_n         = 1'b0;
    bus.req_valid = 2'b00;
    @(posedge clk); #1;
    rst_n    = 1'b1;
    prio_m   = 1'b0;
    exp_idle = 1'b1;
    chk("midop_rst_busy",  CW'(busy),          CW'(1'b0));
    chk("midop_rst_inpa",  CW'(alu_inpa),      CW'(64'd0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("midop_no_rsp", CW'(bus.rsp_valid), CW'(2'b00));
    end
    run_op(2'b11, 0, rdy);
    chk("midop_prio0", CW'(rdy), CW'(2'b01));
    bus.req_valid = 2'b00;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
